// File: rtl/accel_regs_pkg.sv
// Register map, reset values and FSM encoding shared by the accelerometer SPI responder.
package accel_regs_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam logic [7:0] RST_BW_RATE     = 8'h0A;
  localparam logic [7:0] RST_POWER_CTL   = 8'h00;
  localparam logic [7:0] RST_DATA_FORMAT = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for a slow SPI pin with registered-edge rise/fall pulses.
module spi_pin_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= (sync_q << 1) | Stages'(d_i);
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// Mode-3 SPI responder emulating the accelerometer: command decode, small register file and
// coherent axis-sample readout, with all SPI pins oversampled in the clk_i domain.
module accel_spi_responder
  import accel_regs_pkg::*;
#(
  parameter logic [7:0]  DevId      = 8'hE5,
  parameter int unsigned SyncStages = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [15:0] sample_x_i,
  input  logic [15:0] sample_y_i,
  input  logic [15:0] sample_z_i,
  input  logic        sample_valid_i,
  output logic [7:0]  power_ctl_o,
  output logic [7:0]  data_format_o,
  output logic [7:0]  bw_rate_o,
  output logic        measure_o,
  output logic        wr_strobe_o,
  output logic [5:0]  wr_addr_o
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SyncStages-1:0] mosi_q;
  logic mosi_sync;

  spi_pin_sync #(
    .Stages  (SyncStages),
    .ResetVal(1'b1)
  ) u_sclk_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (sclk_i),
    .q_o   (sclk_sync),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // Reset low: a frame already in progress at reset release never shows a falling edge.
  spi_pin_sync #(
    .Stages  (SyncStages),
    .ResetVal(1'b0)
  ) u_cs_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (cs_n_i),
    .q_o   (cs_sync),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= (mosi_q << 1) | SyncStages'(mosi_i);
    end
  end
  assign mosi_sync = mosi_q[SyncStages-1];

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [5:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        mb_q, mb_d;
  logic        commit;
  logic [7:0]  rx_byte;
  logic [5:0]  next_addr;

  logic [7:0]  power_ctl_q, data_format_q, bw_rate_q;
  logic        wr_strobe_q;
  logic [5:0]  wr_addr_q;
  logic [15:0] shadow_x_q, shadow_y_q, shadow_z_q;
  logic [15:0] pend_x_q, pend_y_q, pend_z_q;
  logic        pending_q;
  logic        armed_q;

  assign rx_byte   = {rx_q, mosi_sync};
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

  function automatic logic [7:0] reg_read(input logic [5:0] addr);
    case (addr)
      ADDR_DEVID:       reg_read = DevId;
      ADDR_BW_RATE:     reg_read = bw_rate_q;
      ADDR_POWER_CTL:   reg_read = power_ctl_q;
      ADDR_DATA_FORMAT: reg_read = data_format_q;
      ADDR_DATAX0:      reg_read = shadow_x_q[7:0];
      ADDR_DATAX1:      reg_read = shadow_x_q[15:8];
      ADDR_DATAY0:      reg_read = shadow_y_q[7:0];
      ADDR_DATAY1:      reg_read = shadow_y_q[15:8];
      ADDR_DATAZ0:      reg_read = shadow_z_q[7:0];
      ADDR_DATAZ1:      reg_read = shadow_z_q[15:8];
      default:          reg_read = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    mb_d      = mb_q;
    commit    = 1'b0;
    if (cs_rise) begin
      // Any deselect ends the frame; a partial byte is simply dropped.
      state_d   = StIdle;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall && sclk_sync) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
            miso_d    = 1'b0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = rx_byte[7];
              mb_d    = rx_byte[6];
              addr_d  = rx_byte[5:0];
              tx_d    = rx_byte[7] ? reg_read(rx_byte[5:0]) : 8'h00;
              state_d = StData;
            end
          end
        end
        StData: begin
          if (sclk_rise) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              commit = ~rw_q;
              addr_d = next_addr;
              tx_d   = rw_q ? reg_read(next_addr) : 8'h00;
            end
          end else if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      addr_q    <= 6'd0;
      rw_q      <= 1'b0;
      mb_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      mb_q      <= mb_d;
      armed_q   <= armed_q | cs_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      power_ctl_q   <= RST_POWER_CTL;
      data_format_q <= RST_DATA_FORMAT;
      bw_rate_q     <= RST_BW_RATE;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 6'd0;
    end else begin
      wr_strobe_q <= commit;
      if (commit) begin
        wr_addr_q <= addr_q;
        case (addr_q)
          ADDR_BW_RATE:     bw_rate_q     <= rx_byte;
          ADDR_POWER_CTL:   power_ctl_q   <= rx_byte;
          ADDR_DATA_FORMAT: data_format_q <= rx_byte;
          default: ;
        endcase
      end
    end
  end

  // Samples arriving mid-frame are parked so a multi-byte read sees one coherent triple.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_x_q <= '0;
      shadow_y_q <= '0;
      shadow_z_q <= '0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_z_q   <= '0;
      pending_q  <= 1'b0;
    end else if (sample_valid_i) begin
      if (state_q != StIdle && !cs_rise) begin
        pend_x_q  <= sample_x_i;
        pend_y_q  <= sample_y_i;
        pend_z_q  <= sample_z_i;
        pending_q <= 1'b1;
      end else begin
        shadow_x_q <= sample_x_i;
        shadow_y_q <= sample_y_i;
        shadow_z_q <= sample_z_i;
        pending_q  <= 1'b0;
      end
    end else if (pending_q && (cs_rise || state_q == StIdle)) begin
      shadow_x_q <= pend_x_q;
      shadow_y_q <= pend_y_q;
      shadow_z_q <= pend_z_q;
      pending_q  <= 1'b0;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = armed_q & ~cs_sync;
  assign power_ctl_o   = power_ctl_q;
  assign data_format_o = data_format_q;
  assign bw_rate_o     = bw_rate_q;
  assign measure_o     = power_ctl_q[3];
  assign wr_strobe_o   = wr_strobe_q;
  assign wr_addr_o     = wr_addr_q;

endmodule
